// File: rtl/dm_access_ctrl.sv
// MEM-stage to DM data-memory access controller: one load/store at a time,
// with address checking and a timeout against a memory that never answers.
module dm_access_ctrl #(
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              DMclka,
    output logic              DMena,
    output logic              DMwea,
    output logic [ADDR_W-1:0] DMaddra,
    output logic [DATA_W-1:0] DMdina,
    input  logic [DATA_W-1:0] DMdouta,
    input  logic              DMdone
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                addr_bad;

    // Misaligned or beyond the DM word range: rejected without touching DM.
    assign addr_bad = (req_addr[1:0] != 2'b00) || (req_addr[31:ADDR_W+2] != '0);

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr[ADDR_W+1:2];
                    wdata_d = req_wdata;
                    cnt_d   = '0;
                    rdata_d = '0;
                    err_d   = addr_bad;
                    state_d = addr_bad ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS: begin
                // A done strobe on the final allowed cycle still completes cleanly.
                if (DMdone) begin
                    rdata_d = we_q ? '0 : DMdouta;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    rdata_d = '0;
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign DMclka     = clk;
    assign DMena      = (state_q == S_ACCESS);
    assign DMwea      = (state_q == S_ACCESS) && we_q;
    assign DMaddra    = addr_q;
    assign DMdina     = wdata_q;
endmodule

// File: tb/tb_dm_access_ctrl.sv
// Bench for dm_access_ctrl: directed scenarios plus randomized requests against
// a word-array reference model of memory and the access/error/timeout rules.
module tb_dm_access_ctrl;
    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid, req_ready, req_we;
    logic [31:0]       req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid, resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic              DMclka, DMena, DMwea, DMdone;
    logic [ADDR_W-1:0] DMaddra;
    logic [DATA_W-1:0] DMdina, DMdouta;

    int errors = 0;
    int checks = 0;
    int ena_cycles = 0;

    logic [DATA_W-1:0] dm_mem  [128];  // environment memory behind the DM port
    logic [DATA_W-1:0] ref_mem [128];  // what the reference model expects memory to hold

    dm_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .DMclka(DMclka), .DMena(DMena), .DMwea(DMwea), .DMaddra(DMaddra),
        .DMdina(DMdina), .DMdouta(DMdouta), .DMdone(DMdone)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (DMena) ena_cycles++;

    // One full request. delay = ACCESS cycle (1-based) on which DMdone pulses;
    // delay > TIMEOUT means DM never answers. stall = cycles resp_ready held low.
    task automatic do_req(input logic we, input logic [31:0] addr,
                          input logic [DATA_W-1:0] wdata, input int delay,
                          input int stall);
        logic              bad;
        logic              exp_err;
        logic [DATA_W-1:0] exp_rdata;
        int                idx;
        int                exp_ena;
        int                ena_start;
        bool_done: begin end
        bad     = (addr[1:0] != 2'b00) || (addr[31:9] != 23'd0);
        idx     = int'(addr[8:2]);
        exp_err = bad || (delay > TIMEOUT);
        exp_ena = bad ? 0 : ((delay > TIMEOUT) ? TIMEOUT : delay);
        exp_rdata = (!exp_err && !we) ? ref_mem[idx] : '0;
        if (!exp_err && we) ref_mem[idx] = wdata;

        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL idle_req_ready got=%b want=1", req_ready);
        end
        ena_start = ena_cycles;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0;
        if (!bad) begin
            for (int k = 1; k <= TIMEOUT; k++) begin
                checks++;
                if (DMena !== 1'b1 || DMwea !== we || DMaddra !== addr[8:2] ||
                    (we && DMdina !== wdata) || req_ready !== 1'b0 || resp_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL access_port cyc=%0d ena=%b wea=%b addra=%0d dina=%h rdy=%b vld=%b want ena=1 wea=%b addra=%0d dina=%h",
                             k, DMena, DMwea, DMaddra, DMdina, req_ready, resp_valid, we, addr[8:2], wdata);
                end
                DMdone  = (k == delay);
                DMdouta = dm_mem[idx];
                @(negedge clk);
                DMdone  = 1'b0;
                DMdouta = $urandom;
                if (k == delay) begin
                    if (we) dm_mem[idx] = wdata;
                    break;
                end
            end
        end
        checks++;
        if (ena_cycles - ena_start != exp_ena) begin
            errors++; $display("FAIL ena_cycle_count got=%0d want=%0d", ena_cycles - ena_start, exp_ena);
        end
        for (int s = 0; s <= stall; s++) begin
            checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== exp_rdata || resp_err !== exp_err ||
                req_ready !== 1'b0 || DMena !== 1'b0 || DMwea !== 1'b0) begin
                errors++;
                $display("FAIL resp addr=%h we=%b s=%0d vld=%b rdata=%h err=%b rdy=%b ena=%b want vld=1 rdata=%h err=%b rdy=0 ena=0",
                         addr, we, s, resp_valid, resp_rdata, resp_err, req_ready, DMena, exp_rdata, exp_err);
            end
            resp_ready = (s == stall);
            @(negedge clk);
        end
        resp_ready = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL back_to_idle vld=%b rdy=%b want vld=0 rdy=1", resp_valid, req_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== '0 || resp_err !== 1'b0 ||
            DMena !== 1'b0 || DMwea !== 1'b0 || DMaddra !== '0 || DMdina !== '0) begin
            errors++;
            $display("FAIL reset_values rdy=%b vld=%b rdata=%h err=%b ena=%b wea=%b addra=%0d dina=%h want 1,0,0,0,0,0,0,0",
                     req_ready, resp_valid, resp_rdata, resp_err, DMena, DMwea, DMaddra, DMdina);
        end
        rst = 1'b0;
    endtask

    task automatic test_load();
        dm_mem[5] = 32'hDEADBEEF; ref_mem[5] = 32'hDEADBEEF;
        do_req(1'b0, 32'h14, 32'h0, 1, 0);
    endtask

    task automatic test_store();
        do_req(1'b1, 32'h1FC, 32'h12345678, 3, 0);
        do_req(1'b0, 32'h1FC, 32'h0, 1, 0);
    endtask

    task automatic test_errors();
        do_req(1'b0, 32'h6, 32'h0, 1, 0);
        do_req(1'b1, 32'h200, 32'hCAFE0000, 1, 0);
    endtask

    task automatic test_timeout();
        do_req(1'b0, 32'h40, 32'h0, TIMEOUT + 5, 0);
        do_req(1'b0, 32'h40, 32'h0, TIMEOUT, 0);
    endtask

    task automatic test_backpressure();
        do_req(1'b0, 32'h14, 32'h0, 2, 5);
        do_req(1'b0, 32'h7, 32'h0, 1, 5);
    endtask

    task automatic test_reset_mid_access();
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hA5A5A5A5;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== '0 || resp_err !== 1'b0 ||
            DMena !== 1'b0 || DMwea !== 1'b0 || DMaddra !== '0 || DMdina !== '0) begin
            errors++;
            $display("FAIL reset_mid_access rdy=%b vld=%b rdata=%h err=%b ena=%b wea=%b addra=%0d dina=%h want 1,0,0,0,0,0,0,0",
                     req_ready, resp_valid, resp_rdata, resp_err, DMena, DMwea, DMaddra, DMdina);
        end
        DMdone = 1'b1;
        @(negedge clk);
        DMdone = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (resp_valid !== 1'b0 || req_ready !== 1'b1 || DMena !== 1'b0) begin
                errors++; $display("FAIL late_done_ignored vld=%b rdy=%b ena=%b want 0,1,0", resp_valid, req_ready, DMena);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        int          kind;
        logic [31:0] a;
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 9);
            a    = {23'd0, 7'($urandom_range(0, 127)), 2'b00};
            if (kind == 0) a[1:0] = 2'($urandom_range(1, 3));
            else if (kind == 1) a = ($urandom | 32'h200) & 32'hFFFF_FFFC;
            do_req(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(1, TIMEOUT + 2),
                   $urandom_range(0, 3));
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        resp_ready = 1'b0; DMdone = 1'b0; DMdouta = '0;
        for (int i = 0; i < 128; i++) begin
            dm_mem[i]  = $urandom;
            ref_mem[i] = dm_mem[i];
        end
        test_reset();
        test_load();
        test_store();
        test_errors();
        test_timeout();
        test_backpressure();
        test_reset_mid_access();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
